// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory2c between instruction fetch and the
// memory stage, holding the memory LATENCY cycles per access and sequencing the halt dump.
module mem_arbiter #(
   parameter int LATENCY      = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   input  logic        dm_req,
   input  logic        dm_wr,
   input  logic [15:0] dm_addr,
   input  logic [15:0] dm_wdata,
   input  logic        halt,
   input  logic [15:0] mem_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic        mem_createdump,
   output logic [15:0] rdata,
   output logic        if_done,
   output logic        dm_done,
   output logic        if_stall,
   output logic        dm_stall,
   output logic        busy
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [1:0] DUMP = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] count;
   logic [SW-1:0] streak;
   logic          grant_dm;
   logic          dump_seen;
   logic [15:0]   lat_addr;
   logic [15:0]   lat_wdata;
   logic          lat_wr;

   // dump_seen blocks a second dump until halt has been observed low again
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         streak    <= '0;
         grant_dm  <= 1'b0;
         dump_seen <= 1'b0;
         lat_addr  <= 16'h0000;
         lat_wdata <= 16'h0000;
         lat_wr    <= 1'b0;
         rdata     <= 16'h0000;
      end else begin
         if (!halt) dump_seen <= 1'b0;
         case (state)
            IDLE: begin
               if (dm_req && ((streak < SMAX) || !if_req)) begin
                  grant_dm  <= 1'b1;
                  lat_addr  <= dm_addr;
                  lat_wdata <= dm_wdata;
                  lat_wr    <= dm_wr;
                  count     <= LAST;
                  state     <= BUSY;
                  if (if_req) streak <= (streak == SMAX) ? SMAX : streak + 1'b1;
                  else        streak <= '0;
               end else if (if_req) begin
                  grant_dm  <= 1'b0;
                  lat_addr  <= if_addr;
                  lat_wdata <= 16'h0000;
                  lat_wr    <= 1'b0;
                  count     <= LAST;
                  state     <= BUSY;
                  streak    <= '0;
               end else if (halt && !dump_seen) begin
                  dump_seen <= 1'b1;
                  state     <= DUMP;
               end
            end
            BUSY: begin
               if (count == '0) begin
                  rdata <= lat_wr ? 16'h0000 : mem_rdata;
                  state <= DONE;
               end else begin
                  count <= count - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Memory-side outputs are forced to zero whenever no access is in flight
   assign busy           = (state == BUSY);
   assign mem_enable     = busy;
   assign mem_addr       = busy ? lat_addr  : 16'h0000;
   assign mem_wdata      = busy ? lat_wdata : 16'h0000;
   assign mem_wr         = busy & lat_wr;
   assign mem_createdump = (state == DUMP);
   assign if_done        = (state == DONE) & ~grant_dm;
   assign dm_done        = (state == DONE) & grant_dm;
   assign if_stall       = if_req & ~if_done;
   assign dm_stall       = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=4 instance against a word memory
// model, plus a LATENCY=1 instance for the short-latency corner.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   logic        if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0, halt = 1'b0;
   logic [15:0] if_addr = 16'h0, dm_addr = 16'h0, dm_wdata = 16'h0;
   logic [15:0] mem_rdata, mem_addr, mem_wdata, rdata;
   logic        mem_enable, mem_wr, mem_createdump, if_done, dm_done, if_stall, dm_stall, busy;

   mem_arbiter #(.LATENCY(4), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .halt(halt), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_enable(mem_enable),
      .mem_wr(mem_wr), .mem_createdump(mem_createdump), .rdata(rdata),
      .if_done(if_done), .dm_done(dm_done), .if_stall(if_stall), .dm_stall(dm_stall),
      .busy(busy)
   );

   logic        if_req1 = 1'b0, dm_req1 = 1'b0, dm_wr1 = 1'b0;
   logic [15:0] if_addr1 = 16'h0, dm_addr1 = 16'h0, dm_wdata1 = 16'h0;
   logic [15:0] mem_addr1, mem_wdata1, rdata1;
   logic        mem_enable1, mem_wr1, mem_createdump1, if_done1, dm_done1, if_stall1, dm_stall1, busy1;

   mem_arbiter #(.LATENCY(1), .STARVE_LIMIT(4)) dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1),
      .dm_req(dm_req1), .dm_wr(dm_wr1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
      .halt(1'b0), .mem_rdata(16'hA5A5),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_enable(mem_enable1),
      .mem_wr(mem_wr1), .mem_createdump(mem_createdump1), .rdata(rdata1),
      .if_done(if_done1), .dm_done(dm_done1), .if_stall(if_stall1), .dm_stall(dm_stall1),
      .busy(busy1)
   );

   // Word memory model: combinational read, write on the rising edge while enabled
   logic [15:0] mem [0:65535];
   assign mem_rdata = mem[mem_addr];

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h0000] = 16'hC0DE;
      mem[16'h0010] = 16'h1234;
      forever begin
         @(posedge clk);
         if (mem_enable && mem_wr) mem[mem_addr] = mem_wdata;
      end
   end

   typedef struct {
      logic        is_dm;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      int          exp_wr_cycles;
   } vec_t;

   localparam int EXP_LAT = 5;
   localparam int EXP_EN  = 4;

   vec_t vecs [0:6];
   int   checks = 0;
   int   fails  = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One complete access on the LATENCY=4 instance, checked against the vector
   task automatic applyStimulus(input vec_t v, input string tag);
      int          lat, en_cyc, wr_cyc;
      logic        seen, stall_ok, addr_ok;
      logic [15:0] got;
      lat = 0; en_cyc = 0; wr_cyc = 0; seen = 1'b0; stall_ok = 1'b1; addr_ok = 1'b1; got = 16'h0;
      @(posedge clk); #1;
      if (v.is_dm) begin
         dm_req = 1'b1; dm_wr = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); #1;
         lat++;
         if (mem_enable) begin
            en_cyc++;
            if (mem_addr !== v.addr) addr_ok = 1'b0;
         end
         if (mem_wr) wr_cyc++;
         if (lat == 1) begin
            if_addr = 16'hDEAD; dm_addr = 16'hDEAD; dm_wdata = 16'h0BAD; dm_wr = ~v.wr;
         end
         if ((v.is_dm ? dm_done : if_done) === 1'b1) begin
            seen = 1'b1;
            got  = rdata;
            if ((v.is_dm ? dm_stall : if_stall) !== 1'b0) stall_ok = 1'b0;
            if ((v.is_dm ? if_done : dm_done) !== 1'b0) stall_ok = 1'b0;
         end else if ((v.is_dm ? dm_stall : if_stall) !== 1'b1) begin
            stall_ok = 1'b0;
         end
      end
      if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
      checkOutput({tag, "_latency"}, seen ? lat : 99, EXP_LAT);
      checkOutput({tag, "_rdata"}, got, v.exp_rdata);
      checkOutput({tag, "_enable_cycles"}, en_cyc, EXP_EN);
      checkOutput({tag, "_wr_cycles"}, wr_cyc, v.exp_wr_cycles);
      checkOutput({tag, "_addr_stall"}, {addr_ok, stall_ok}, 2'b11);
   endtask

   initial begin
      int          n, dumps, done_cyc, dump_cyc, stray;
      logic [9:0]  order;
      logic        en_at_dump;

      vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 0};
      vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 4};
      vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 0};
      vecs[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 0};
      vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 4};
      vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 0};
      vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hC0DE, 0};

      doReset();
      checkOutput("reset_outputs",
                  {mem_addr, mem_wdata, rdata, busy, mem_enable, mem_wr, mem_createdump,
                   if_done, dm_done, if_stall, dm_stall}, 64'h0);

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      // Both requesters held high: DM wins four times, then IF gets a turn
      doReset();
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 16'h0010; dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0000;
      n = 0; order = '0;
      for (int c = 0; c < 200 && n < 10; c++) begin
         @(posedge clk); #1;
         if (dm_done) begin order = {order[8:0], 1'b1}; n++; end
         else if (if_done) begin order = {order[8:0], 1'b0}; n++; end
      end
      if_req = 1'b0; dm_req = 1'b0;
      checkOutput("starve_grants", n, 10);
      checkOutput("starve_order", order, 10'b1111011110);

      // Reset on the second BUSY cycle aborts the access without a done pulse
      doReset();
      applyStimulus(vecs[0], "pre_abort");
      @(posedge clk); #1;
      dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h5555;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("abort_busy_before", {busy, mem_wr, mem_addr}, {2'b11, 16'h0030});
      rst = 1'b1; dm_req = 1'b0; dm_wr = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_outputs",
                  {mem_addr, mem_wdata, rdata, busy, mem_enable, mem_wr, mem_createdump,
                   if_done, dm_done}, 64'h0);
      rst = 1'b0;
      stray = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (if_done || dm_done || busy) stray++;
      end
      checkOutput("abort_no_done", stray, 0);
      applyStimulus(vecs[2], "post_abort");

      // halt raised mid-access: access finishes, then exactly one dump
      doReset();
      @(posedge clk); #1;
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
      @(posedge clk); #1;
      halt = 1'b1;
      dumps = 0; done_cyc = -1; dump_cyc = -1; en_at_dump = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (dm_done) begin done_cyc = c; dm_req = 1'b0; end
         if (mem_createdump) begin dumps++; dump_cyc = c; en_at_dump = mem_enable; end
      end
      checkOutput("halt_dump_count", dumps, 1);
      checkOutput("halt_dump_after_done", dump_cyc - done_cyc, 2);
      checkOutput("halt_dump_enable", en_at_dump, 1'b0);
      halt = 1'b0;
      repeat (2) @(posedge clk);
      #1 halt = 1'b1;
      dumps = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (mem_createdump) dumps++;
      end
      halt = 1'b0;
      checkOutput("halt_rearm_count", dumps, 1);

      // LATENCY=1 instance: done two cycles after the request
      doReset();
      @(posedge clk); #1;
      checkOutput("l1_idle_stall", {if_stall1, dm_stall1}, 2'b00);
      if_req1 = 1'b1; if_addr1 = 16'h0042;
      #1;
      checkOutput("l1_pending", {if_stall1, if_done1, busy1}, 3'b100);
      @(posedge clk); #1;
      checkOutput("l1_busy", {if_stall1, if_done1, busy1, mem_enable1, mem_addr1}, {4'b1011, 16'h0042});
      @(posedge clk); #1;
      checkOutput("l1_done", {if_stall1, if_done1, busy1, rdata1}, {3'b010, 16'hA5A5});
      if_req1 = 1'b0;
      @(posedge clk); #1;
      checkOutput("l1_after", {if_stall1, if_done1, busy1}, 3'b000);
      dm_req1 = 1'b1; dm_wr1 = 1'b1; dm_addr1 = 16'h0007; dm_wdata1 = 16'h7777;
      @(posedge clk); #1;
      checkOutput("l1_dm_busy", {dm_stall1, mem_wr1, mem_wdata1}, {2'b11, 16'h7777});
      @(posedge clk); #1;
      checkOutput("l1_dm_done", {dm_stall1, dm_done1, rdata1}, {2'b01, 16'h0000});
      dm_req1 = 1'b0; dm_wr1 = 1'b0;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
